ahb_mem_bridge: RTL and testbench

//  Single-transfer AHB-Lite master that sits directly downstream of the multicycle controller's memory controls.

---
 rtl/ahb_pkg.sv | 33 +++
 rtl/ahb_lane_align.sv | 42 ++++
 rtl/ahb_mem_bridge.sv | 153 +++++++++++++++
 tb/tb_ahb_mem_bridge.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite constants and bridge state type shared by the memory bridge files.
//   HTRANS_*  : transfer type encodings used by the bridge (IDLE, NONSEQ)
//   HSIZE_*   : transfer size encodings (byte, halfword, word)
//   HBURST_*  : burst encoding (SINGLE only)
//   bridge_state_t : IDLE -> ADDR -> DATA sequencing of one transfer
//   size_to_hsize  : maps the controller's 2-bit size code onto HSIZE
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } bridge_state_t;

  // Size code 3 is not a legal request size; it is treated as a word.
  function automatic logic [2:0] size_to_hsize(input logic [1:0] size);
    case (size)
      2'd0:    return HSIZE_BYTE;
      2'd1:    return HSIZE_HALF;
      default: return HSIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Combinational byte-lane steering for the AHB memory bridge.
//   hsize       in  3       latched transfer size (HSIZE encoding)
//   addr_lo     in  2       original (unaligned) request address bits [1:0]
//   wdata       in  DATA_W  store data, right-justified
//   wdata_lanes out DATA_W  store data replicated across all lanes for HWDATA
//   hrdata      in  DATA_W  raw read data from the bus
//   rdata       out DATA_W  selected lane, zero-extended
// Only DATA_W = 32 is supported.
module ahb_lane_align
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        hsize,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] wdata_lanes,
  input  logic [DATA_W-1:0] hrdata,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    wdata_lanes = wdata;
    rdata       = hrdata;
    case (hsize)
      HSIZE_BYTE: begin
        wdata_lanes = {4{wdata[7:0]}};
        rdata       = {24'h0, hrdata[{addr_lo, 3'b000} +: 8]};
      end
      HSIZE_HALF: begin
        // addr_lo[0] is ignored: the bus address was forced to half alignment.
        wdata_lanes = {2{wdata[15:0]}};
        rdata       = {16'h0, hrdata[{addr_lo[1], 4'b0000} +: 16]};
      end
      default: begin
        wdata_lanes = wdata;
        rdata       = hrdata;
      end
    endcase
  end

endmodule

// File: rtl/ahb_mem_bridge.sv
// Single-transfer AHB-Lite master fed by the multicycle controller's memory controls.
// Each accepted request becomes one NONSEQ/SINGLE transfer; stall stays high until the
// one-cycle rsp_valid pulse, and read data is returned lane-steered and zero-extended.
//   clk, reset (async, active-high)
//   req_valid/req_ready/req_write/req_size/req_addr/req_wdata : request side
//   stall, rsp_valid, rsp_rdata, rsp_err                       : response side
//   HADDR HTRANS HWRITE HSIZE HBURST HPROT HWDATA               : AHB master outputs (registered)
//   HRDATA HREADY HRESP                                         : AHB slave inputs
// Build option: define AHB_BRIDGE_ERR_EN to honour HRESP (error completes with rsp_err=1 and
// leaves rsp_rdata untouched). Without it HRESP is ignored and rsp_err is constant 0.
module ahb_mem_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  bridge_state_t state_q, state_d;

  logic              write_q;
  logic [2:0]        hsize_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] haddr_q;
  logic [1:0]        htrans_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [2:0]        req_hsize;
  logic [ADDR_W-1:0] req_haddr;
  logic [DATA_W-1:0] wdata_lanes;
  logic [DATA_W-1:0] rdata_lane;
  logic              accept, addr_done, data_done, xfer_err;

`ifdef AHB_BRIDGE_ERR_EN
  assign xfer_err = HRESP;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign xfer_err     = 1'b0;
`endif

  assign accept    = (state_q == IDLE) && req_valid;
  assign addr_done = (state_q == ADDR) && HREADY;
  assign data_done = (state_q == DATA) && HREADY;

  // Bus address is aligned to the transfer size; the raw low bits are kept for steering.
  always_comb begin
    req_hsize = size_to_hsize(req_size);
    req_haddr = req_addr;
    if (req_hsize == HSIZE_HALF) begin
      req_haddr[0] = 1'b0;
    end else if (req_hsize == HSIZE_WORD) begin
      req_haddr[1:0] = 2'b00;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = ADDR;
      ADDR:    if (HREADY)    state_d = DATA;
      DATA:    if (HREADY)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  ahb_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .hsize      (hsize_q),
    .addr_lo    (addr_lo_q),
    .wdata      (wdata_q),
    .wdata_lanes(wdata_lanes),
    .hrdata     (HRDATA),
    .rdata      (rdata_lane)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      hsize_q     <= HSIZE_BYTE;
      addr_lo_q   <= 2'b00;
      wdata_q     <= '0;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= data_done;
      rsp_err_q   <= data_done && xfer_err;
      if (accept) begin
        write_q   <= req_write;
        hsize_q   <= req_hsize;
        addr_lo_q <= req_addr[1:0];
        wdata_q   <= req_wdata;
        haddr_q   <= req_haddr;
        htrans_q  <= HTRANS_NONSEQ;
      end
      if (addr_done) begin
        htrans_q <= HTRANS_IDLE;
        hwdata_q <= wdata_lanes;
      end
      if (data_done && !write_q && !xfer_err) begin
        rsp_rdata_q <= rdata_lane;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = write_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_ahb_mem_bridge.sv
// Directed self-checking bench for ahb_mem_bridge. A bus-slave driver task runs one transfer
// with a chosen number of ADDR/DATA wait states and records what the bridge showed; each
// test task then compares those observations against hand-computed values.
module tb_ahb_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_vec = 0;
  int n_bad = 0;

  // Observations of the most recent transfer.
  logic [31:0] obs_haddr, obs_hwdata, obs_rdata;
  logic [2:0]  obs_hsize;
  logic        obs_hwrite, obs_err, obs_hold_ok, obs_ready_rsp, obs_stall_rsp;
  logic [1:0]  obs_htrans, obs_htrans_data;
  int          obs_lat;

  ahb_mem_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size (req_size),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .stall    (stall),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HWDATA   (HWDATA),
    .HRDATA   (HRDATA),
    .HREADY   (HREADY),
    .HRESP    (HRESP)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept on the first edge, then aw ADDR waits, then dw DATA waits. Returns in the
  // cycle where rsp_valid is seen (or after a bounded number of extra cycles).
  task automatic run_xfer(input logic w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int aw, input int dw,
                          input logic [31:0] rd, input logic err);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hFFFF_FFFF;
    tick;
    // Scramble request inputs so only latched values can reach the bus.
    req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_addr = ~a; req_wdata = ~wd;
    obs_haddr   = HADDR;
    obs_hsize   = HSIZE;
    obs_hwrite  = HWRITE;
    obs_htrans  = HTRANS;
    obs_hold_ok = (stall === 1'b1) && (rsp_valid === 1'b0) && (req_ready === 1'b0);
    for (int i = 0; i < aw; i++) begin
      HREADY = 1'b0;
      tick;
      if (HADDR !== obs_haddr || HTRANS !== obs_htrans || HSIZE !== obs_hsize ||
          HWRITE !== obs_hwrite || stall !== 1'b1 || rsp_valid !== 1'b0) obs_hold_ok = 1'b0;
    end
    HREADY = 1'b1;
    tick;
    obs_htrans_data = HTRANS;
    obs_hwdata      = HWDATA;
    if (stall !== 1'b1 || rsp_valid !== 1'b0) obs_hold_ok = 1'b0;
    HRDATA = rd;
    HRESP  = err;
    for (int i = 0; i < dw; i++) begin
      HREADY = 1'b0;
      tick;
      if (HWDATA !== obs_hwdata || HTRANS !== 2'b00 || stall !== 1'b1 ||
          rsp_valid !== 1'b0) obs_hold_ok = 1'b0;
    end
    HREADY = 1'b1;
    tick;
    HRESP  = 1'b0;
    HRDATA = 32'hFFFF_FFFF;
    obs_lat = aw + dw + 3;
    while (rsp_valid !== 1'b1 && obs_lat < 40) begin
      tick;
      obs_lat++;
    end
    obs_rdata     = rsp_rdata;
    obs_err       = rsp_err;
    obs_ready_rsp = req_ready;
    obs_stall_rsp = stall;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_addr = 32'h0; req_wdata = 32'h0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    tick; tick;
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
    n_vec++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL reset_htrans got %b exp 00", HTRANS); end
    n_vec++; if (HADDR !== 32'h0) begin n_bad++; $display("FAIL reset_haddr got %h exp 0", HADDR); end
    n_vec++; if (HWRITE !== 1'b0) begin n_bad++; $display("FAIL reset_hwrite got %b exp 0", HWRITE); end
    n_vec++; if (HSIZE !== 3'd0) begin n_bad++; $display("FAIL reset_hsize got %0d exp 0", HSIZE); end
    n_vec++; if (HWDATA !== 32'h0) begin n_bad++; $display("FAIL reset_hwdata got %h exp 0", HWDATA); end
    n_vec++; if (HBURST !== 3'b000) begin n_bad++; $display("FAIL reset_hburst got %b exp 000", HBURST); end
    n_vec++; if (HPROT !== 4'b0011) begin n_bad++; $display("FAIL reset_hprot got %b exp 0011", HPROT); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_word_read;
    run_xfer(1'b0, 2'd2, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    n_vec++; if (obs_lat != 3) begin n_bad++; $display("FAIL wr_latency got %0d exp 3", obs_lat); end
    n_vec++; if (obs_htrans !== 2'b10) begin n_bad++; $display("FAIL wr_htrans_addr got %b exp 10", obs_htrans); end
    n_vec++; if (obs_htrans_data !== 2'b00) begin n_bad++; $display("FAIL wr_htrans_data got %b exp 00", obs_htrans_data); end
    n_vec++; if (obs_haddr !== 32'h100) begin n_bad++; $display("FAIL wr_haddr got %h exp 100", obs_haddr); end
    n_vec++; if (obs_hsize !== 3'd2) begin n_bad++; $display("FAIL wr_hsize got %0d exp 2", obs_hsize); end
    n_vec++; if (obs_hwrite !== 1'b0) begin n_bad++; $display("FAIL wr_hwrite got %b exp 0", obs_hwrite); end
    n_vec++; if (obs_hold_ok !== 1'b1) begin n_bad++; $display("FAIL wr_stall_window got %b exp 1", obs_hold_ok); end
    n_vec++; if (obs_stall_rsp !== 1'b0) begin n_bad++; $display("FAIL wr_stall_at_rsp got %b exp 0", obs_stall_rsp); end
    n_vec++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rdata got %h exp deadbeef", obs_rdata); end
    n_vec++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b exp 0", obs_err); end
    tick;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_pulse_width got %b exp 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rdata_held got %h exp deadbeef", rsp_rdata); end
  endtask

  task automatic test_byte_lanes;
    run_xfer(1'b1, 2'd0, 32'h103, 32'h0000_005A, 0, 0, 32'h0, 1'b0);
    n_vec++; if (obs_haddr !== 32'h103) begin n_bad++; $display("FAIL bw_haddr got %h exp 103", obs_haddr); end
    n_vec++; if (obs_hsize !== 3'd0) begin n_bad++; $display("FAIL bw_hsize got %0d exp 0", obs_hsize); end
    n_vec++; if (obs_hwrite !== 1'b1) begin n_bad++; $display("FAIL bw_hwrite got %b exp 1", obs_hwrite); end
    n_vec++; if (obs_hwdata !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL bw_hwdata got %h exp 5a5a5a5a", obs_hwdata); end
    n_vec++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bw_rdata_kept got %h exp deadbeef", obs_rdata); end
    tick;
    run_xfer(1'b0, 2'd0, 32'h102, 32'h0, 0, 0, 32'h1122_3344, 1'b0);
    n_vec++; if (obs_haddr !== 32'h102) begin n_bad++; $display("FAIL br_haddr got %h exp 102", obs_haddr); end
    n_vec++; if (obs_rdata !== 32'h0000_0022) begin n_bad++; $display("FAIL br_rdata got %h exp 00000022", obs_rdata); end
    tick;
  endtask

  task automatic test_half_lanes;
    run_xfer(1'b0, 2'd1, 32'h107, 32'h0, 0, 0, 32'hAABB_CCDD, 1'b0);
    n_vec++; if (obs_haddr !== 32'h106) begin n_bad++; $display("FAIL hr_haddr got %h exp 106", obs_haddr); end
    n_vec++; if (obs_hsize !== 3'd1) begin n_bad++; $display("FAIL hr_hsize got %0d exp 1", obs_hsize); end
    n_vec++; if (obs_rdata !== 32'h0000_AABB) begin n_bad++; $display("FAIL hr_rdata got %h exp 0000aabb", obs_rdata); end
    tick;
    run_xfer(1'b1, 2'd1, 32'h102, 32'hFFFF_1234, 0, 0, 32'h0, 1'b0);
    n_vec++; if (obs_haddr !== 32'h102) begin n_bad++; $display("FAIL hw_haddr got %h exp 102", obs_haddr); end
    n_vec++; if (obs_hwdata !== 32'h1234_1234) begin n_bad++; $display("FAIL hw_hwdata got %h exp 12341234", obs_hwdata); end
    tick;
    // Size code 3 behaves as a word.
    run_xfer(1'b0, 2'd3, 32'h10B, 32'h0, 0, 0, 32'h0102_0304, 1'b0);
    n_vec++; if (obs_haddr !== 32'h108) begin n_bad++; $display("FAIL s3_haddr got %h exp 108", obs_haddr); end
    n_vec++; if (obs_hsize !== 3'd2) begin n_bad++; $display("FAIL s3_hsize got %0d exp 2", obs_hsize); end
    n_vec++; if (obs_rdata !== 32'h0102_0304) begin n_bad++; $display("FAIL s3_rdata got %h exp 01020304", obs_rdata); end
    tick;
  endtask

  task automatic test_wait_states;
    run_xfer(1'b1, 2'd2, 32'h200, 32'hCAFE_F00D, 3, 2, 32'h0, 1'b0);
    n_vec++; if (obs_lat != 8) begin n_bad++; $display("FAIL ws_latency got %0d exp 8", obs_lat); end
    n_vec++; if (obs_hold_ok !== 1'b1) begin n_bad++; $display("FAIL ws_outputs_held got %b exp 1", obs_hold_ok); end
    n_vec++; if (obs_haddr !== 32'h200) begin n_bad++; $display("FAIL ws_haddr got %h exp 200", obs_haddr); end
    n_vec++; if (obs_hwdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ws_hwdata got %h exp cafef00d", obs_hwdata); end
    n_vec++; if (obs_rdata !== 32'h0102_0304) begin n_bad++; $display("FAIL ws_rdata_kept got %h exp 01020304", obs_rdata); end
    tick;
  endtask

  task automatic test_back_to_back;
    run_xfer(1'b0, 2'd2, 32'h300, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0);
    n_vec++; if (obs_ready_rsp !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_rsp got %b exp 1", obs_ready_rsp); end
    run_xfer(1'b0, 2'd0, 32'h301, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0);
    n_vec++; if (obs_lat != 3) begin n_bad++; $display("FAIL b2b_latency got %0d exp 3", obs_lat); end
    n_vec++; if (obs_rdata !== 32'h0000_00F0) begin n_bad++; $display("FAIL b2b_rdata got %h exp 000000f0", obs_rdata); end
    tick;
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h400; HREADY = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    HREADY = 1'b0;
    reset  = 1'b1;
    #1;
    n_vec++; if (HTRANS !== 2'b00) begin n_bad++; $display("FAIL rm_htrans got %b exp 00", HTRANS); end
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got %b exp 1", req_ready); end
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rm_stall got %b exp 0", stall); end
    HREADY = 1'b1;
    tick;
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_rsp got %b exp 0", rsp_valid); end
    reset = 1'b0;
    run_xfer(1'b0, 2'd2, 32'h500, 32'h0, 0, 0, 32'h1234_5678, 1'b0);
    n_vec++; if (obs_lat != 3) begin n_bad++; $display("FAIL rm_after_latency got %0d exp 3", obs_lat); end
    n_vec++; if (obs_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rm_after_rdata got %h exp 12345678", obs_rdata); end
    tick;
  endtask

  task automatic test_error;
    logic        exp_err;
    logic [31:0] exp_rdata;
`ifdef AHB_BRIDGE_ERR_EN
    exp_err   = 1'b1;
    exp_rdata = 32'h1234_5678;
`else
    exp_err   = 1'b0;
    exp_rdata = 32'h9999_9999;
`endif
    run_xfer(1'b0, 2'd2, 32'h600, 32'h0, 0, 1, 32'h9999_9999, 1'b1);
    n_vec++; if (obs_lat != 4) begin n_bad++; $display("FAIL er_latency got %0d exp 4", obs_lat); end
    n_vec++; if (obs_err !== exp_err) begin n_bad++; $display("FAIL er_flag got %b exp %b", obs_err, exp_err); end
    n_vec++; if (obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL er_rdata got %h exp %h", obs_rdata, exp_rdata); end
    tick;
    n_vec++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL er_flag_clear got %b exp 0", rsp_err); end
    run_xfer(1'b0, 2'd2, 32'h604, 32'h0, 0, 0, 32'h00C0_FFEE, 1'b0);
    n_vec++; if (obs_err !== 1'b0) begin n_bad++; $display("FAIL er_next_flag got %b exp 0", obs_err); end
    n_vec++; if (obs_rdata !== 32'h00C0_FFEE) begin n_bad++; $display("FAIL er_next_rdata got %h exp 00c0ffee", obs_rdata); end
    tick;
  endtask

  initial begin
    test_reset;
    test_word_read;
    test_byte_lanes;
    test_half_lanes;
    test_wait_states;
    test_back_to_back;
    test_reset_mid;
    test_error;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
